// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes on both sides. Results and {Z,N,V}
// hold in DONE until consumed; mul runs as a WIDTH-cycle shift-add sequence.
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       status,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_ASR = 3'b111;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t               state, state_n;
    logic [2*WIDTH-1:0]   acc, acc_n, mcand, mcand_n;
    logic [WIDTH-1:0]     mplier, mplier_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [WIDTH-1:0]     res_n;
    logic [2:0]           stat_n;

    logic [WIDTH-1:0]     bx, sum, alu_res;
    logic                 alu_v;

    // Sub shares the adder: a + ~b + 1. V from operand/result sign agreement.
    always_comb begin
        bx      = (op == OP_SUB) ? ~b : b;
        sum     = a + bx + WIDTH'(op == OP_SUB);
        alu_res = '0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                alu_res = sum;
                alu_v   = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_NOT:  alu_res = ~b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_ASR:  alu_res = WIDTH'($signed(a) >>> b[SHW-1:0]);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_n  = state;
        acc_n    = acc;
        mcand_n  = mcand;
        mplier_n = mplier;
        cnt_n    = cnt;
        res_n    = result;
        stat_n   = status;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (op == OP_MUL) begin
                        state_n  = MUL;
                        acc_n    = '0;
                        cnt_n    = '0;
                        mcand_n  = {{WIDTH{1'b0}}, a};
                        mplier_n = b;
                    end else begin
                        state_n = DONE;
                        res_n   = alu_res;
                        stat_n  = {alu_res == '0, alu_res[WIDTH-1], alu_v};
                    end
                end
            end
            MUL: begin
                acc_n    = acc + (mplier[0] ? mcand : '0);
                mcand_n  = mcand << 1;
                mplier_n = mplier >> 1;
                cnt_n    = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_n = DONE;
                    res_n   = acc_n[WIDTH-1:0];
                    stat_n  = {acc_n[WIDTH-1:0] == '0, acc_n[WIDTH-1], |acc_n[2*WIDTH-1:WIDTH]};
                end
            end
            DONE: begin
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            result <= '0;
            status <= '0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            mcand  <= mcand_n;
            mplier <= mplier_n;
            cnt    <= cnt_n;
            result <= res_n;
            status <= stat_n;
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == MUL);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed literal cases plus random traffic, every cycle
// compared against a transaction-level model of the handshake and arithmetic.
module tb_seq_alu;

    localparam int W = 16;
    localparam longint MAXS = (longint'(1) << (W - 1)) - 1;
    localparam longint MINS = -(longint'(1) << (W - 1));

    logic         clk = 1'b0;
    logic         reset, in_valid, out_ready;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         in_ready, out_valid, busy;
    logic [W-1:0] result;
    logic [2:0]   status;

    int errors = 0;
    int checks = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .status(status), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Arithmetic reference: plain integer math on the operands.
    function automatic void ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] r, output logic [2:0] s);
        longint sx, sy, t, p;
        logic signed [W-1:0] xs;
        logic v;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        v = 1'b0;
        r = '0;
        case (o)
            3'd0: begin t = sx + sy; r = x + y; v = (t > MAXS) || (t < MINS); end
            3'd1: begin t = sx - sy; r = x - y; v = (t > MAXS) || (t < MINS); end
            3'd2: r = x & y;
            3'd3: r = ~y;
            3'd4: r = x | y;
            3'd5: r = x ^ y;
            3'd6: begin
                p = longint'(x) * longint'(y);
                r = p[W-1:0];
                v = (p >> W) != 0;
            end
            default: begin
                xs = x;
                r = xs >>> (int'(y) % W);
            end
        endcase
        s = {r == '0, r[W-1], v};
    endfunction

    // Transaction-level model: phase 0 idle, 1 multiplying, 2 holding a result.
    int           m_phase = 0;
    int           m_left = 0;
    logic [W-1:0] m_res = '0, m_pr = '0, m_r;
    logic [2:0]   m_stat = '0, m_ps = '0, m_s;
    logic         armed = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0;
            m_res   = '0;
            m_stat  = '0;
            armed   = 1'b1;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    ref_op(op, a, b, m_r, m_s);
                    if (op == 3'd6) begin
                        m_phase = 1; m_left = W; m_pr = m_r; m_ps = m_s;
                    end else begin
                        m_phase = 2; m_res = m_r; m_stat = m_s;
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = 2; m_res = m_pr; m_stat = m_ps; end
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("in_ready",  32'(in_ready),  32'(m_phase == 0));
            chk("busy",      32'(busy),      32'(m_phase == 1));
            chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
            chk("result",    32'(result),    32'(m_res));
            chk("status",    32'(status),    32'(m_stat));
        end
    end

    // Presents an op and returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        @(negedge clk);
        in_valid = 1'b1; op = o; a = x; b = y;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits for out_valid; lat counts edges after the accept edge, nbusy the busy cycles.
    task automatic wait_out(input bit noise, output logic [W-1:0] r, output logic [2:0] s,
                            output int lat, output int nbusy);
        lat = 0; nbusy = 0;
        while (!out_valid && lat < 100) begin
            if (busy) nbusy++;
            if (noise) begin
                out_ready = 1'($urandom);
                in_valid = 1'($urandom); op = 3'($urandom); a = W'($urandom); b = W'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        if (!out_valid) chk("result_timeout", 32'(out_valid), 32'd1);
        r = result; s = status;
    endtask

    task automatic consume(input int hold, input bit noise);
        out_ready = 1'b0;
        repeat (hold) begin
            if (noise) begin
                in_valid = 1'($urandom); op = 3'($urandom); a = W'($urandom); b = W'($urandom);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        if (noise) in_valid = 1'($urandom);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] r, output logic [2:0] s, output int lat, output int nb);
        issue(o, x, y);
        wait_out(1'b0, r, s, lat, nb);
        consume(0, 1'b0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom % 5)
            0: return '0;
            1: return W'(16'h8000);
            2: return W'(16'h7FFF);
            3: return W'($urandom % 4);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] r, pr;
        logic [2:0]   s, ps;
        int           lat, nb;
        logic [2:0]   o;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        reset = 1'b0;

        ref_op(3'd7, 16'h8000, 16'hFFF4, r, s);
        chk("model_asr", 32'(r), 32'hF800);
        ref_op(3'd6, 16'h0100, 16'h0100, r, s);
        chk("model_mul", 32'({r, s}), 32'({16'h0000, 3'b101}));

        run_op(3'd0, 16'h7FFF, 16'h0001, r, s, lat, nb);
        chk("add_res", 32'(r), 32'h8000); chk("add_st", 32'(s), 32'b011); chk("add_lat", 32'(lat), 32'd0);
        run_op(3'd1, 16'h0005, 16'h0005, r, s, lat, nb);
        chk("sub0_res", 32'(r), 32'h0000); chk("sub0_st", 32'(s), 32'b100);
        run_op(3'd1, 16'h8000, 16'h0001, r, s, lat, nb);
        chk("subv_res", 32'(r), 32'h7FFF); chk("subv_st", 32'(s), 32'b001);
        run_op(3'd6, 16'h0003, 16'h0005, r, s, lat, nb);
        chk("mul_res", 32'(r), 32'h000F); chk("mul_st", 32'(s), 32'b000);
        chk("mul_lat", 32'(lat), 32'd16); chk("mul_busy", 32'(nb), 32'd16);
        run_op(3'd6, 16'h0100, 16'h0100, r, s, lat, nb);
        chk("mulv_res", 32'(r), 32'h0000); chk("mulv_st", 32'(s), 32'b101);
        run_op(3'd7, 16'h8000, 16'h0004, r, s, lat, nb);
        chk("asr_res", 32'(r), 32'hF800); chk("asr_st", 32'(s), 32'b010);
        run_op(3'd7, 16'h8000, 16'hFFF4, r, s, lat, nb);
        chk("asr_hi_res", 32'(r), 32'hF800);
        run_op(3'd3, 16'h1234, 16'hFFFF, r, s, lat, nb);
        chk("notb_res", 32'(r), 32'h0000); chk("notb_st", 32'(s), 32'b100);

        // Backpressure with a competing request held on the input.
        issue(3'd0, 16'h1234, 16'h0001);
        pr = result; ps = status;
        chk("bp_res0", 32'(pr), 32'h1235);
        in_valid = 1'b1; op = 3'd5; a = 16'hFF00; b = 16'h0F0F;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_res", 32'(result), 32'(pr));
            chk("bp_hold_st", 32'(status), 32'(ps));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_idle", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_res", 32'(result), 32'hF00F);
        chk("bp_next_st", 32'(status), 32'b010);
        consume(0, 1'b0);

        // Reset during the seventh MUL cycle.
        issue(3'd6, 16'h00FF, 16'h00FF);
        repeat (6) @(negedge clk);
        chk("rm_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rm_out_valid", 32'(out_valid), 32'd0);
        chk("rm_busy", 32'(busy), 32'd0);
        chk("rm_in_ready", 32'(in_ready), 32'd1);
        chk("rm_result", 32'(result), 32'd0);
        chk("rm_status", 32'(status), 32'd0);
        run_op(3'd0, 16'h0001, 16'h0001, r, s, lat, nb);
        chk("rm_add", 32'(r), 32'h0002);

        for (int i = 0; i < 300; i++) begin
            o = 3'($urandom);
            issue(o, pick(), pick());
            wait_out(1'b1, r, s, lat, nb);
            chk("rand_lat", 32'(lat), (o == 3'd6) ? 32'd16 : 32'd0);
            consume(int'($urandom % 4), 1'b1);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, registered successor to the datapath's combinational ALU. Accepts one operation per valid/ready handshake, computes it, and holds the result and the status flags {zero, negative, overflow} until a consumer accepts them. Adds OR, XOR, arithmetic right shift and an iterative shift-add multiply to the add/sub/and/not set. Sits between the register-file operand latches and the writeback/status register of the next-generation datapath.

Parameters:
WIDTH, 16, operand and result width in bits (minimum 4).
SHW, $clog2(WIDTH), width of the shift-amount field taken from b[SHW-1:0].

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  operands and op presented.
in_ready  output  1  block can accept an operation.
op  input  3  000 add, 001 sub, 010 and, 011 not-b, 100 or, 101 xor, 110 mul, 111 asr.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B (shift amount for asr).
out_valid  output  1  result and status valid.
out_ready  input  1  consumer accepts the result.
result  output  WIDTH  registered result.
status  output  3  {Z, N, V}, registered and valid with out_valid.
busy  output  1  high in MUL state.

Behaviour:
- One clock, synchronous active-high reset. Reset state: IDLE, in_ready=1, out_valid=0, busy=0, result=0, status=000, multiply accumulator and counter cleared.
- States: IDLE, MUL, DONE. in_ready = (state==IDLE). busy = (state==MUL). out_valid = (state==DONE).
- Accept: an operation is accepted on a rising edge where in_valid && in_ready. In any other state, in_valid is ignored and a, b and op are not sampled.
- Single-cycle ops (all except 110): on the accept edge, result and status are registered and the state goes to DONE. out_valid is high in the cycle after the accept edge.
- add and sub: WIDTH-bit two's complement; sub computes a + ~b + 1.
  - V = carry into the MSB xor carry out of the MSB.
- and, or, xor, not-b (result = ~b): V=0.
- asr: result = a arithmetically shifted right by b[SHW-1:0]; upper bits of b are ignored; V=0.
- mul: unsigned a*b, computed over exactly WIDTH MUL cycles.
  - Accept edge: enter MUL, counter=0, 2*WIDTH-bit accumulator=0, latch the multiplicand and multiplier.
  - Each MUL edge processes one multiplier bit, LSB first: if the bit is 1, add the shifted multiplicand to the accumulator.
  - On the WIDTH-th MUL edge: result = acc[WIDTH-1:0], V = |acc[2*WIDTH-1:WIDTH], go to DONE.
  - out_valid rises WIDTH edges after the accept edge.
- Z = (result == 0); N = result[WIDTH-1]. Both apply to every op.
- DONE: result and status hold stable while out_ready=0. On an edge with out_ready=1, go to IDLE; out_valid falls and in_ready rises in the next cycle. No same-cycle accept in DONE, so peak throughput is one op per 2 cycles.
- result and status are unchanged in IDLE and MUL; they keep the last delivered values.
- Undefined op encodings: none; all 8 codes are defined.
- Reset has priority over every event. If asserted in MUL or DONE, the next cycle is IDLE with all outputs at reset values; the in-flight result is discarded.
- out_ready while not in DONE has no effect.

Test Plan:
1. WIDTH=16, add a=0x7FFF b=0x0001 -> result 0x8000, status 011, out_valid in the cycle after accept.
2. sub a=0x0005 b=0x0005 -> result 0x0000, status 100. Then sub a=0x8000 b=0x0001 -> result 0x7FFF, status 001.
3. mul a=0x0003 b=0x0005 -> result 0x000F, status 000, busy high for exactly 16 cycles, out_valid 16 edges after accept. Then mul a=0x0100 b=0x0100 -> result 0x0000, status 101.
4. asr a=0x8000 b=0x0004 -> result 0xF800, status 010. Then asr with b=0xFFF4 (only the low 4 bits, 4, are used) -> result 0xF800. Then not-b b=0xFFFF -> result 0x0000, status 100.
5. Backpressure: after an add, hold out_ready=0 for 5 cycles while driving in_valid=1 with new operands -> result and status stable, in_ready=0, the new op is not taken. Raising out_ready -> IDLE next cycle, then the pending in_valid is accepted.
6. Reset mid-operation: assert reset at MUL cycle 7 of a mul -> next cycle out_valid=0, busy=0, in_ready=1, result=0x0000, status=000. A following add 0x0001+0x0001 returns 0x0002.
